stream_packet_fifo: RTL and testbench

Avalon-ST packet FIFO placed directly downstream of the endian swapper. It absorbs back-pressure from the sink and stores every beat with its data, empty, startofpacket and endofpacket fields. It counts forwarded packets, tracks a fill high-water mark and flags framing violations. All of this is exposed through an Avalon-MM CSR port.

---
 rtl/stream_pkg.sv | 19 +
 rtl/stream_fifo_mem.sv | 24 ++
 rtl/stream_packet_fifo.sv | 162 ++++++++++++++++
 tb/tb_stream_packet_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream packet FIFO: CSR map and beat layout.
package stream_pkg;

    localparam int unsigned STREAM_DATA_BYTES = 8;
    localparam int unsigned STREAM_EMPTY_W    = $clog2(STREAM_DATA_BYTES);

    localparam logic [1:0] CSR_LEVEL = 2'd0;
    localparam logic [1:0] CSR_PKTS  = 2'd1;
    localparam logic [1:0] CSR_HWM   = 2'd2;
    localparam logic [1:0] CSR_ERRS  = 2'd3;

    typedef struct packed {
        logic [STREAM_DATA_BYTES*8-1:0] data;
        logic [STREAM_EMPTY_W-1:0]      empty;
        logic                           sop;
        logic                           eop;
    } beat_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// Beat storage: DEPTH x WIDTH register array, synchronous write, asynchronous read.
module stream_fifo_mem #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_packet_fifo.sv
// Show-ahead Avalon-ST packet FIFO with packet/framing counters, fill high-water
// mark and an Avalon-MM CSR port (readLatency 1).
module stream_packet_fifo
    import stream_pkg::*;
#(
    parameter int unsigned DATA_BYTES = STREAM_DATA_BYTES,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BYTES*8-1:0]       stream_in_data,
    input  logic [$clog2(DATA_BYTES)-1:0] stream_in_empty,
    input  logic                          stream_in_valid,
    input  logic                          stream_in_startofpacket,
    input  logic                          stream_in_endofpacket,
    output logic                          stream_in_ready,
    output logic [DATA_BYTES*8-1:0]       stream_out_data,
    output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
    output logic                          stream_out_valid,
    output logic                          stream_out_startofpacket,
    output logic                          stream_out_endofpacket,
    input  logic                          stream_out_ready,
    input  logic [1:0]                    csr_address,
    input  logic                          csr_read,
    input  logic                          csr_write,
    input  logic [31:0]                   csr_writedata,
    output logic [31:0]                   csr_readdata,
    output logic                          csr_readdatavalid,
    output logic                          csr_waitrequest
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = DATA_BYTES * 8;
    localparam int unsigned EW = $clog2(DATA_BYTES);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
    } fifo_beat_t;

    logic [PW-1:0] wr_ptr, rd_ptr, level, level_nxt;
    logic          full, fifo_empty, push, pop;
    logic          in_packet, frame_err;
    logic [31:0]   pkt_count, hwm, err_count, level32, level_nxt32;
    logic [31:0]   csr_mux;
    logic          wr_hwm, wr_errs;
    logic          unused_writedata;
    fifo_beat_t    in_beat, out_beat;

    assign level       = wr_ptr - rd_ptr;
    assign full        = (level == PW'(DEPTH));
    assign fifo_empty  = (level == '0);
    assign push        = stream_in_valid & ~full;
    assign pop         = ~fifo_empty & stream_out_ready;
    assign level_nxt   = level + PW'(push) - PW'(pop);
    assign level32     = 32'(level);
    assign level_nxt32 = 32'(level_nxt);

    assign stream_in_ready  = ~full;
    assign stream_out_valid = ~fifo_empty;

    assign in_beat = '{data:  stream_in_data,
                       empty: stream_in_empty,
                       sop:   stream_in_startofpacket,
                       eop:   stream_in_endofpacket};

    stream_fifo_mem #(
        .WIDTH ($bits(fifo_beat_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_beat),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (out_beat)
    );

    assign stream_out_data          = out_beat.data;
    assign stream_out_empty         = out_beat.empty;
    assign stream_out_startofpacket = out_beat.sop;
    assign stream_out_endofpacket   = out_beat.eop;

    // A beat is out of frame when its sop disagrees with the packet state.
    assign frame_err = push & (stream_in_startofpacket ? in_packet : ~in_packet);

    // A simultaneous read wins; the write is dropped.
    assign wr_hwm  = csr_write & ~csr_read & (csr_address == CSR_HWM);
    assign wr_errs = csr_write & ~csr_read & (csr_address == CSR_ERRS);

    assign unused_writedata = ^csr_writedata;
    assign csr_waitrequest  = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            in_packet <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (stream_in_endofpacket) begin
                    in_packet <= 1'b0;
                end else if (stream_in_startofpacket) begin
                    in_packet <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count <= '0;
            hwm       <= '0;
            err_count <= '0;
        end else begin
            if (pop && out_beat.eop) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (wr_hwm) begin
                hwm <= level32;
            end else if (level_nxt32 > hwm) begin
                hwm <= level_nxt32;
            end
            if (wr_errs) begin
                err_count <= '0;
            end else if (frame_err) begin
                err_count <= err_count + 32'd1;
            end
        end
    end

    always_comb begin
        csr_mux = '0;
        case (csr_address)
            CSR_LEVEL: csr_mux = level32;
            CSR_PKTS:  csr_mux = pkt_count;
            CSR_HWM:   csr_mux = hwm;
            CSR_ERRS:  csr_mux = err_count;
            default:   csr_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata      <= '0;
            csr_readdatavalid <= 1'b0;
        end else begin
            csr_readdatavalid <= csr_read;
            if (csr_read) begin
                csr_readdata <= csr_mux;
            end
        end
    end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Directed self-checking bench for stream_packet_fifo (DATA_BYTES=8, DEPTH=16).
module tb_stream_packet_fifo;
    import stream_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] stream_in_data = '0;
    logic [2:0]  stream_in_empty = '0;
    logic        stream_in_valid = 1'b0;
    logic        stream_in_startofpacket = 1'b0;
    logic        stream_in_endofpacket = 1'b0;
    logic        stream_in_ready;
    logic [63:0] stream_out_data;
    logic [2:0]  stream_out_empty;
    logic        stream_out_valid;
    logic        stream_out_startofpacket;
    logic        stream_out_endofpacket;
    logic        stream_out_ready = 1'b0;
    logic [1:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        csr_waitrequest;

    int total = 0;
    int bad   = 0;

    stream_packet_fifo #(
        .DATA_BYTES (8),
        .DEPTH      (16)
    ) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .stream_in_data           (stream_in_data),
        .stream_in_empty          (stream_in_empty),
        .stream_in_valid          (stream_in_valid),
        .stream_in_startofpacket  (stream_in_startofpacket),
        .stream_in_endofpacket    (stream_in_endofpacket),
        .stream_in_ready          (stream_in_ready),
        .stream_out_data          (stream_out_data),
        .stream_out_empty         (stream_out_empty),
        .stream_out_valid         (stream_out_valid),
        .stream_out_startofpacket (stream_out_startofpacket),
        .stream_out_endofpacket   (stream_out_endofpacket),
        .stream_out_ready         (stream_out_ready),
        .csr_address              (csr_address),
        .csr_read                 (csr_read),
        .csr_write                (csr_write),
        .csr_writedata            (csr_writedata),
        .csr_readdata             (csr_readdata),
        .csr_readdatavalid        (csr_readdatavalid),
        .csr_waitrequest          (csr_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic sop,
                         input logic eop, input logic [2:0] emp);
        stream_in_valid         = v;
        stream_in_data          = d;
        stream_in_startofpacket = sop;
        stream_in_endofpacket   = eop;
        stream_in_empty         = emp;
    endtask

    task automatic csr_rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        csr_address = addr;
        csr_read    = 1'b1;
        step();
        csr_read = 1'b0;
        chk({tag, "_rdv"}, 64'(csr_readdatavalid), 64'd1);
        chk(tag, 64'(csr_readdata), 64'(exp));
        step();
        chk({tag, "_rdv_drop"}, 64'(csr_readdatavalid), 64'd0);
    endtask

    task automatic csr_wr(input logic [1:0] addr);
        csr_address   = addr;
        csr_writedata = 32'hFFFF_FFFF;
        csr_write     = 1'b1;
        step();
        csr_write = 1'b0;
    endtask

    initial begin
        int cnt;
        beat_t b;

        // reset state
        #2;
        chk("rst_out_valid", 64'(stream_out_valid), 64'd0);
        chk("rst_in_ready", 64'(stream_in_ready), 64'd1);
        chk("rst_rdv", 64'(csr_readdatavalid), 64'd0);
        chk("rst_rdata", 64'(csr_readdata), 64'd0);
        chk("waitrequest", 64'(csr_waitrequest), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // 4-beat packet, sink always ready: each beat emerges one cycle later
        stream_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b.data  = 64'h1000 + 64'(i);
            b.sop   = (i == 0);
            b.eop   = (i == 3);
            b.empty = (i == 3) ? 3'd3 : 3'd0;
            drive(1'b1, b.data, b.sop, b.eop, b.empty);
            step();
            chk("pkt4_valid", 64'(stream_out_valid), 64'd1);
            chk("pkt4_data", stream_out_data, b.data);
            chk("pkt4_sop", 64'(stream_out_startofpacket), 64'(b.sop));
            chk("pkt4_eop", 64'(stream_out_endofpacket), 64'(b.eop));
            chk("pkt4_empty", 64'(stream_out_empty), 64'(b.empty));
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        step();
        chk("pkt4_drained", 64'(stream_out_valid), 64'd0);
        csr_rd(CSR_PKTS, 32'd1, "pkt4_pkts");
        csr_rd(CSR_LEVEL, 32'd0, "pkt4_level");

        // fill with sink stalled
        stream_out_ready = 1'b0;
        cnt = 0;
        while (cnt < 40) begin
            drive(1'b1, 64'(cnt), cnt == 0, 1'b0, '0);
            if (!stream_in_ready) break;
            step();
            cnt++;
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        chk("fill_count", 64'(cnt), 64'd16);
        csr_rd(CSR_LEVEL, 32'd16, "fill_level");
        csr_rd(CSR_HWM, 32'd16, "fill_hwm");

        // release: ready returns one cycle after the first pop
        stream_out_ready = 1'b1;
        chk("full_in_ready", 64'(stream_in_ready), 64'd0);
        chk("drain_head0", stream_out_data, 64'd0);
        step();
        chk("in_ready_back", 64'(stream_in_ready), 64'd1);
        for (int k = 1; k < 8; k++) begin
            chk("drain_order", stream_out_data, 64'(k));
            step();
        end

        // simultaneous push/pop at level 8
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, 64'(16 + j), 1'b0, j == 19, '0);
            chk("pp_head", stream_out_data, 64'(8 + j));
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        stream_out_ready = 1'b0;
        csr_rd(CSR_LEVEL, 32'd8, "pp_level");
        stream_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("pp_tail", stream_out_data, 64'(28 + k));
            step();
        end
        chk("pp_empty", 64'(stream_out_valid), 64'd0);
        csr_rd(CSR_PKTS, 32'd2, "pp_pkts");
        csr_rd(CSR_ERRS, 32'd0, "pp_errs");
        csr_rd(CSR_HWM, 32'd16, "pp_hwm");

        // framing: sop, sop, eop, orphan data beat
        drive(1'b1, 64'hA0, 1'b1, 1'b0, '0); step();
        drive(1'b1, 64'hA1, 1'b1, 1'b0, '0); step();
        drive(1'b1, 64'hA2, 1'b0, 1'b1, '0); step();
        drive(1'b1, 64'hA3, 1'b0, 1'b0, '0); step();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        step();
        chk("frame_drained", 64'(stream_out_valid), 64'd0);
        csr_rd(CSR_ERRS, 32'd2, "frame_errs");
        csr_address = CSR_ERRS;
        csr_read    = 1'b1;
        csr_write   = 1'b1;
        step();
        csr_read  = 1'b0;
        csr_write = 1'b0;
        chk("rdwr_data", 64'(csr_readdata), 64'd2);
        step();
        csr_rd(CSR_ERRS, 32'd2, "rdwr_kept");
        csr_wr(CSR_ERRS);
        csr_rd(CSR_ERRS, 32'd0, "errs_cleared");

        // hwm load at level 5
        stream_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(100 + i), i == 0, i == 4, '0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        csr_wr(CSR_HWM);
        chk("hwm_rdv_idle", 64'(csr_readdatavalid), 64'd0);
        csr_rd(CSR_HWM, 32'd5, "hwm_load");
        csr_rd(CSR_LEVEL, 32'd5, "lvl5");

        // reset with 6 beats of an open packet stored
        stream_out_ready = 1'b1;
        repeat (5) step();
        chk("pre_rst_empty", 64'(stream_out_valid), 64'd0);
        stream_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 64'(200 + i), i == 0, 1'b0, '0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        csr_rd(CSR_LEVEL, 32'd6, "pre_rst_level");
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(stream_out_valid), 64'd0);
        chk("arst_in_ready", 64'(stream_in_ready), 64'd1);
        chk("arst_rdata", 64'(csr_readdata), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        csr_rd(CSR_LEVEL, 32'd0, "arst_level");
        csr_rd(CSR_PKTS, 32'd0, "arst_pkts");
        csr_rd(CSR_HWM, 32'd0, "arst_hwm");
        csr_rd(CSR_ERRS, 32'd0, "arst_errs");

        stream_out_ready = 1'b1;
        drive(1'b1, 64'hB0, 1'b1, 1'b0, '0); step();
        chk("post_rst_head", stream_out_data, 64'hB0);
        drive(1'b1, 64'hB1, 1'b0, 1'b1, 3'd5); step();
        chk("post_rst_tail", stream_out_data, 64'hB1);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        step();
        csr_rd(CSR_ERRS, 32'd0, "post_rst_errs");
        csr_rd(CSR_PKTS, 32'd1, "post_rst_pkts");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
